md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multiply/divide sequencer for the five-stage MIPS pipeline; sits in the E stage beside the ALU.
- Accepts the decoder's multiply/divide start class (MULT, MULTU, DIV, DIVU) and the HI/LO move-to ops (MTHI, MTLO).
- Runs a fixed-latency multi-cycle operation, owns the HI/LO registers, and drives the D-stage stall request for dependent HI/LO instructions.
- Suppresses issue when the instruction in E is being cancelled by an exception or interrupt.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  E-stage instruction is a md-class op (mult/multu/div/divu/mthi/mtlo)
md_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 ignored
src_a  in  32  forwarded rs value in E
src_b  in  32  forwarded rt value in E
exc_req  in  1  E-stage instruction cancelled this cycle; blocks issue
d_md_use  in  1  D-stage instruction reads or writes HI/LO (mult..mtlo, mfhi, mflo)
busy  out  1  operation in flight
stall  out  1  stall request to the hazard unit for the D stage
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, busy=0, hi=0, lo=0, captured operands=0. Any in-flight operation is abandoned; no partial HI/LO write.
- issue = op_valid & ~exc_req & md_op in {0..3}.
- mt_wr = op_valid & ~exc_req & md_op in {4,5}.
- States:
  - IDLE: on issue, capture src_a, src_b and md_op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - RUN: decrement the counter each cycle. When counter==1, at that edge write HI/LO and return to IDLE.
- Timing: issue at edge E0 gives busy=1 for exactly N cycles (E0..EN). At edge EN, HI/LO take their new values and busy falls in the same edge.
- Issue while in RUN cannot occur because stall prevents it. If it does occur, it is ignored: no restart and no assertion in RTL.
- Results, computed on the captured operands only (later src changes have no effect):
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divisor==0 (DIV/DIVU): the operation still occupies DIV_CYCLES, but hi and lo are left unchanged.
- MTHI/MTLO: single-cycle write of src_a into hi/lo at the next edge; no busy. Legal only in IDLE; stall guarantees this.
- stall = d_md_use & (busy | issue). This is combinational, so the D instruction is held in the same cycle a start is seen in E.
- exc_req with issue in the same cycle: no capture, no state change, stall is not raised by that issue.
- exc_req during RUN has no effect: the issued instruction already committed past E.
- hi/lo are readable combinationally by mfhi/mflo in E when not stalled.

Decomposition:
- Shared package constants: md_op encodings (MD_MULT..MD_MTLO), the default cycle counts, and the IDLE/RUN state encoding.
- One natural sub-module, md_compute: purely combinational 64-bit multiply and 32-bit divide/remainder of the captured operands. It returns {hi_new, lo_new} and a div_by_zero flag.
- Counter, FSM and HI/LO registers stay in md_sequencer.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- MULTU 0xFFFFFFFF x 2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Change src_a mid-operation; the result must be unchanged.
- DIV -7/2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
- MULT issued with d_md_use=1 (mflo in D) -> stall=1 in the issue cycle and all 5 busy cycles, stall=0 the cycle after hi/lo update. MTLO 0x1234 in IDLE -> lo=0x1234 next cycle, busy never asserted.
- DIV with exc_req=1 in the same cycle -> busy stays 0, hi/lo unchanged, stall=0. DIV issued, then exc_req=1 during cycle 3 -> completes normally.
- DIV issued, reset_n pulsed low mid-cycle at busy cycle 4 -> busy, hi and lo go to 0 immediately (async). After release, IDLE with no late write.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: md_op encodings,
// default operation latencies and the sequencer state encoding.
package md_sequencer_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the four ops that start a multi-cycle operation.
  function automatic logic is_start_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide ops.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two ops that interpret operands as signed.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Purely combinational multiply/divide datapath for md_sequencer.
// Ports:
//   op_i          captured md_op (only MULT/MULTU/DIV/DIVU are meaningful)
//   a_i, b_i      captured operands (rs, rt)
//   result_o      {hi_new, lo_new}: 64-bit product, or {remainder, quotient}
//   div_by_zero_o divide op with a zero divisor; result_o must not be written
module md_compute
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic        sgn_s;
  logic        div_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] prod_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Product and quotient/remainder of the captured operands.
  always_comb begin
    sgn_s   = is_signed_op(op_i);
    div_s   = is_div_op(op_i);
    // Low 64 bits of a 64x64 product of sign-extended operands equal the
    // signed 32x32 product, so one multiplier serves both flavours.
    a_ext_s = {{32{sgn_s & a_i[31]}}, a_i};
    b_ext_s = {{32{sgn_s & b_i[31]}}, b_i};
    prod_s  = a_ext_s * b_ext_s;
    // Signed divide is done on magnitudes so that -2^31 / -1 stays defined
    // (magnitude 0x80000000 fits unsigned, re-negation wraps to itself).
    a_mag_s = (sgn_s && a_i[31]) ? (32'd0 - a_i) : a_i;
    b_mag_s = (sgn_s && b_i[31]) ? (32'd0 - b_i) : b_i;
    if (b_mag_s == 32'd0) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    quot_s = (sgn_s && (a_i[31] ^ b_i[31])) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s  = (sgn_s && a_i[31]) ? (32'd0 - r_mag_s) : r_mag_s;
    if (div_s) begin
      result_o = {rem_s, quot_s};
    end else begin
      result_o = prod_s;
    end
    div_by_zero_o = div_s & (b_i == 32'd0);
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: fixed-latency MULT/MULTU/DIV/DIVU,
// HI/LO ownership, MTHI/MTLO writes and the D-stage HI/LO stall request.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   op_valid       E-stage instruction is a md-class op
//   md_op          md op code (MD_MULT..MD_MTLO; 6,7 ignored)
//   src_a, src_b   forwarded rs/rt in E
//   exc_req        E-stage instruction is being cancelled; blocks issue
//   d_md_use       D-stage instruction touches HI/LO
//   busy           operation in flight
//   stall          combinational stall request for the D stage
//   hi, lo         HI/LO registers
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        exc_req,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        issue_s;
  logic        mt_wr_s;
  logic [63:0] result_s;
  logic        div_by_zero_s;

  assign issue_s = op_valid & ~exc_req & is_start_op(md_op);
  assign mt_wr_s = op_valid & ~exc_req & ((md_op == MD_MTHI) || (md_op == MD_MTLO));

  md_compute u_compute (
    .op_i          (op_q),
    .a_i           (a_q),
    .b_i           (b_q),
    .result_o      (result_s),
    .div_by_zero_o (div_by_zero_s)
  );

  // Next-state logic: issue/capture, countdown, completion write, MTHI/MTLO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          op_d    = md_op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = is_div_op(md_op) ? DIV_CNT : MULT_CNT;
          state_d = ST_RUN;
        end else if (mt_wr_s) begin
          if (md_op == MD_MTHI) begin
            hi_d = src_a;
          end else begin
            lo_d = src_a;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Issues and moves arriving here are ignored; stall keeps them out.
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
          if (!div_by_zero_s) begin
            hi_d = result_s[63:32];
            lo_d = result_s[31:0];
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, captured operands and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  // Includes the issue term so the dependent D instruction is held in the
  // very cycle the start is seen in E.
  assign stall = d_md_use & (busy | issue_s);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        exc_req;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .exc_req  (exc_req),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining busy cycles and architectural HI/LO.
  int          m_rem = 0;
  bit          m_write = 1'b0;
  logic [63:0] m_res = 64'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem = 0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 && m_write) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else if (op_valid && !exc_req) begin
      int sa, sb;
      sa = src_a;
      sb = src_b;
      case (md_op)
        3'd0: begin m_res = longint'(sa) * longint'(sb); m_rem = 5; m_write = 1'b1; end
        3'd1: begin m_res = {32'd0, src_a} * {32'd0, src_b}; m_rem = 5; m_write = 1'b1; end
        3'd2: begin
          m_rem = 10; m_write = (sb != 0);
          if (sb != 0) m_res = {32'(sa % sb), 32'(sa / sb)};
        end
        3'd3: begin
          m_rem = 10; m_write = (src_b != 32'd0);
          if (src_b != 32'd0) m_res = {src_a % src_b, src_a / src_b};
        end
        3'd4: m_hi = src_a;
        3'd5: m_lo = src_a;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_rem > 0});
      chk("model_stall", {31'd0, stall},
          {31'd0, d_md_use & ((m_rem > 0) | (op_valid & ~exc_req & (md_op <= 3'd3)))});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  // Issue one op for one cycle, then count busy/stall cycles until done.
  // mod_kind 1: change src_a at busy cycle mod_at; 2: raise exc_req there.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_d, input int mod_at, input int mod_kind,
                       output int nbusy, output int nstall);
    @(posedge clk); #1;
    op_valid = 1'b1; md_op = op; src_a = a; src_b = b; d_md_use = use_d;
    @(posedge clk); #1;
    op_valid = 1'b0;
    nbusy = 0;
    nstall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      if (stall) nstall++;
      if (nbusy == mod_at) begin
        #1;
        if (mod_kind == 1) src_a = 32'hDEAD_BEEF;
        if (mod_kind == 2) exc_req = 1'b1;
      end
    end
  endtask

  initial begin
    int nb, ns;
    reset_n = 1'b0; op_valid = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    exc_req = 1'b0; d_md_use = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en = 1'b1;

    // MULT -3 * 5
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, nb, ns);
    chk("mult_busy_cycles", nb, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2, src_a changed mid-operation
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 2, 1, nb, ns);
    chk("multu_busy_cycles", nb, 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, nb, ns);
    chk("div_busy_cycles", nb, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 7 / 0: full latency, HI/LO unchanged
    do_op(3'd3, 32'd7, 32'd0, 1'b0, 0, 0, nb, ns);
    chk("divu0_busy_cycles", nb, 32'd10);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    // DIV 7 / -2
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 0, nb, ns);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'h0000_0001);

    // MULT with a dependent mflo in D: stall in issue cycle and all busy cycles
    @(posedge clk); #1;
    op_valid = 1'b1; md_op = 3'd0; src_a = 32'd6; src_b = 32'd7; d_md_use = 1'b1;
    @(negedge clk);
    chk("stall_issue_cycle", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    nb = 0; ns = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (stall) ns++;
    end
    chk("stall_busy_cycles", ns, 32'd5);
    chk("stall_after_done", {31'd0, stall}, 32'd0);
    chk("mult67_lo", lo, 32'd42);
    chk("mult67_hi", hi, 32'd0);
    #1; d_md_use = 1'b0;

    // MTLO 0x1234 in IDLE
    @(posedge clk); #1;
    op_valid = 1'b1; md_op = 3'd5; src_a = 32'h0000_1234;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // DIV cancelled in its issue cycle
    @(posedge clk); #1;
    op_valid = 1'b1; exc_req = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd3; d_md_use = 1'b1;
    @(negedge clk);
    chk("exc_issue_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; exc_req = 1'b0; d_md_use = 1'b0;
    repeat (3) @(negedge clk);
    chk("exc_issue_busy", {31'd0, busy}, 32'd0);
    chk("exc_issue_lo", lo, 32'h0000_1234);
    chk("exc_issue_hi", hi, 32'd0);

    // DIV 100 / 7 with exc_req raised during busy cycle 3
    do_op(3'd2, 32'd100, 32'd7, 1'b0, 3, 2, nb, ns);
    #1; exc_req = 1'b0;
    chk("exc_run_busy_cycles", nb, 32'd10);
    chk("exc_run_lo", lo, 32'd14);
    chk("exc_run_hi", hi, 32'd2);

    // DIV interrupted by async reset at busy cycle 4
    @(posedge clk); #1;
    op_valid = 1'b1; md_op = 3'd2; src_a = 32'd50; src_b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (nb >= 4 || !busy) break;
    end
    chk("rst_reached_cycle4", nb, 32'd4);
    #2; reset_n = 1'b0;
    #1;
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_hi", hi, 32'd0);
    chk("rst_async_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_no_late_busy", {31'd0, busy}, 32'd0);
    chk("rst_no_late_lo", lo, 32'd0);
    chk("rst_no_late_hi", hi, 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
